// File: rtl/regfile_pkg.sv
// Shared defaults and index type for the scoreboarded register file.
// Consumers: register_file_sb, rf_scoreboard and the bench.
package regfile_pkg;

  localparam int DEFAULT_DATA_W   = 32;
  localparam int DEFAULT_NUM_REGS = 32;
  localparam int DEFAULT_ADDR_W   = $clog2(DEFAULT_NUM_REGS);

  typedef logic [DEFAULT_ADDR_W-1:0] reg_idx_t;

endpackage

// File: rtl/rf_scoreboard.sv
// One pending bit per register: set on issue, cleared on writeback.
// Bit 0 is never set, so register 0 can never be reported busy.
module rf_scoreboard
  import regfile_pkg::*;
#(
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                set_en,
  input  logic [ADDR_W-1:0]   set_idx,
  input  logic                clr_en,
  input  logic [ADDR_W-1:0]   clr_idx,
  output logic [NUM_REGS-1:0] pending
);

  // Set is tested first so a same-cycle issue and writeback leaves the bit pending.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (set_en && set_idx == ADDR_W'(i)) begin
          pending[i] <= 1'b1;
        end else if (clr_en && clr_idx == ADDR_W'(i)) begin
          pending[i] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with issue scoreboard and stall output.
// Define REGFILE_BYPASS_EN to forward same-cycle writeback data to the read ports.
module register_file_sb
  import regfile_pkg::*;
#(
  parameter  int DATA_W   = DEFAULT_DATA_W,
  parameter  int NUM_REGS = DEFAULT_NUM_REGS,
  localparam int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ReadReg1,
  input  logic [ADDR_W-1:0] ReadReg2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2,
  output logic              Busy1,
  output logic              Busy2,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteReg,
  input  logic [DATA_W-1:0] WriteData,
  input  logic              IssueValid,
  input  logic [ADDR_W-1:0] IssueReg,
  output logic              Stall
);

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending;
  logic                hit1;
  logic                hit2;

  // Register 0 is only ever loaded by reset, which keeps it hard-wired to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (RegWrite && WriteReg != '0) begin
      regs[WriteReg] <= WriteData;
    end
  end

  rf_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (IssueValid),
    .set_idx (IssueReg),
    .clr_en  (RegWrite),
    .clr_idx (WriteReg),
    .pending (pending)
  );

`ifdef REGFILE_BYPASS_EN
  // Gated by rst_n so nothing leaks onto the read ports while in reset.
  assign hit1 = rst_n & RegWrite & (WriteReg != '0) & (WriteReg == ReadReg1);
  assign hit2 = rst_n & RegWrite & (WriteReg != '0) & (WriteReg == ReadReg2);
`else
  assign hit1 = 1'b0;
  assign hit2 = 1'b0;
`endif

  assign ReadData1 = hit1 ? WriteData : regs[ReadReg1];
  assign ReadData2 = hit2 ? WriteData : regs[ReadReg2];
  assign Busy1     = pending[ReadReg1] & ~hit1;
  assign Busy2     = pending[ReadReg2] & ~hit2;
  assign Stall     = (Busy1 | Busy2) & IssueValid;

endmodule

// File: tb/tb_register_file_sb.sv
// Directed self-checking bench for register_file_sb.
// Expectations follow REGFILE_BYPASS_EN when it is defined for the build.
module tb_register_file_sb;
  import regfile_pkg::*;

  logic        clk;
  logic        rst_n;
  reg_idx_t    ReadReg1;
  reg_idx_t    ReadReg2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;
  logic        Busy1;
  logic        Busy2;
  logic        RegWrite;
  reg_idx_t    WriteReg;
  logic [31:0] WriteData;
  logic        IssueValid;
  reg_idx_t    IssueReg;
  logic        Stall;

  int n_cmp;
  int n_err;

  register_file_sb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ReadReg1   (ReadReg1),
    .ReadReg2   (ReadReg2),
    .ReadData1  (ReadData1),
    .ReadData2  (ReadData2),
    .Busy1      (Busy1),
    .Busy2      (Busy2),
    .RegWrite   (RegWrite),
    .WriteReg   (WriteReg),
    .WriteData  (WriteData),
    .IssueValid (IssueValid),
    .IssueReg   (IssueReg),
    .Stall      (Stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite   = 1'b0;
    IssueValid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; RegWrite = 1'b1; WriteReg = 5'd5; WriteData = 32'hFF;
    IssueValid = 1'b1; IssueReg = 5'd5; ReadReg1 = 5'd5; ReadReg2 = 5'd5;
    tick(); tick();
    n_cmp++; if (ReadData1 !== 32'h0) begin n_err++; $display("[TB] FAIL rst_rd1: got %h want 0", ReadData1); end
    n_cmp++; if (ReadData2 !== 32'h0) begin n_err++; $display("[TB] FAIL rst_rd2: got %h want 0", ReadData2); end
    n_cmp++; if (Busy1 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy1: got %b want 0", Busy1); end
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("[TB] FAIL rst_stall: got %b want 0", Stall); end
    idle();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (ReadData1 !== 32'h0) begin n_err++; $display("[TB] FAIL post_rst_rd1: got %h want 0", ReadData1); end
    n_cmp++; if (Busy1 !== 1'b0) begin n_err++; $display("[TB] FAIL post_rst_busy1: got %b want 0", Busy1); end
    // Write and issue presented in the cycle reset deasserts
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; RegWrite = 1'b1; WriteReg = 5'd6; WriteData = 32'h66;
    IssueValid = 1'b1; IssueReg = 5'd6;
    tick();
    idle(); ReadReg1 = 5'd6;
    #1;
    n_cmp++; if (ReadData1 !== 32'h66) begin n_err++; $display("[TB] FAIL deassert_wr: got %h want 66", ReadData1); end
    n_cmp++; if (Busy1 !== 1'b1) begin n_err++; $display("[TB] FAIL deassert_issue: got %b want 1", Busy1); end
    RegWrite = 1'b1; WriteReg = 5'd6; WriteData = 32'h66;
    tick();
    idle();
    #1;
    n_cmp++; if (Busy1 !== 1'b0) begin n_err++; $display("[TB] FAIL deassert_clr: got %b want 0", Busy1); end
  endtask

  task automatic test_write_read();
    RegWrite = 1'b1; WriteReg = 5'd7; WriteData = 32'hDEADBEEF;
    tick();
    idle(); ReadReg1 = 5'd7; ReadReg2 = 5'd7;
    #1;
    n_cmp++; if (ReadData2 !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL wr_rd2: got %h want deadbeef", ReadData2); end
    n_cmp++; if (ReadData1 !== 32'hDEADBEEF) begin n_err++; $display("[TB] FAIL wr_rd1_same: got %h want deadbeef", ReadData1); end
    n_cmp++; if (Busy2 !== 1'b0) begin n_err++; $display("[TB] FAIL wr_nopend: got %b want 0", Busy2); end
  endtask

  task automatic test_r0();
    RegWrite = 1'b1; WriteReg = 5'd0; WriteData = 32'h1234;
    IssueValid = 1'b1; IssueReg = 5'd0; ReadReg1 = 5'd0; ReadReg2 = 5'd0;
    tick();
    for (int c = 0; c < 3; c++) begin
      IssueValid = 1'b1; IssueReg = 5'd0; RegWrite = 1'b0;
      #1;
      n_cmp++; if (ReadData1 !== 32'h0) begin n_err++; $display("[TB] FAIL r0_data c%0d: got %h want 0", c, ReadData1); end
      n_cmp++; if (Busy1 !== 1'b0) begin n_err++; $display("[TB] FAIL r0_busy c%0d: got %b want 0", c, Busy1); end
      n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("[TB] FAIL r0_stall c%0d: got %b want 0", c, Stall); end
      tick();
    end
    idle();
  endtask

  task automatic test_scoreboard();
    IssueValid = 1'b1; IssueReg = 5'd3;
    tick();
    IssueValid = 1'b1; IssueReg = 5'd0; ReadReg1 = 5'd3; ReadReg2 = 5'd0;
    #1;
    n_cmp++; if (Busy1 !== 1'b1) begin n_err++; $display("[TB] FAIL sb_busy: got %b want 1", Busy1); end
    n_cmp++; if (Stall !== 1'b1) begin n_err++; $display("[TB] FAIL sb_stall: got %b want 1", Stall); end
    IssueValid = 1'b0;
    #1;
    n_cmp++; if (Stall !== 1'b0) begin n_err++; $display("[TB] FAIL sb_stall_noissue: got %b want 0", Stall); end
    RegWrite = 1'b1; WriteReg = 5'd3; WriteData = 32'hA5;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (Busy1 !== 1'b0) begin n_err++; $display("[TB] FAIL sb_wb_busy: got %b want 0", Busy1); end
    n_cmp++; if (ReadData1 !== 32'hA5) begin n_err++; $display("[TB] FAIL sb_wb_data: got %h want a5", ReadData1); end
`else
    n_cmp++; if (Busy1 !== 1'b1) begin n_err++; $display("[TB] FAIL sb_wb_busy: got %b want 1", Busy1); end
    n_cmp++; if (ReadData1 !== 32'h0) begin n_err++; $display("[TB] FAIL sb_wb_data: got %h want 0", ReadData1); end
`endif
    tick();
    idle();
    #1;
    n_cmp++; if (Busy1 !== 1'b0) begin n_err++; $display("[TB] FAIL sb_cleared: got %b want 0", Busy1); end
    n_cmp++; if (ReadData1 !== 32'hA5) begin n_err++; $display("[TB] FAIL sb_data: got %h want a5", ReadData1); end
  endtask

  task automatic test_set_clear();
    IssueValid = 1'b1; IssueReg = 5'd4; RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'h44;
    tick();
    idle(); ReadReg2 = 5'd4;
    #1;
    n_cmp++; if (Busy2 !== 1'b1) begin n_err++; $display("[TB] FAIL setclr_busy: got %b want 1", Busy2); end
    n_cmp++; if (ReadData2 !== 32'h44) begin n_err++; $display("[TB] FAIL setclr_data: got %h want 44", ReadData2); end
    RegWrite = 1'b1; WriteReg = 5'd4; WriteData = 32'h45;
    tick();
    idle();
    #1;
    n_cmp++; if (Busy2 !== 1'b0) begin n_err++; $display("[TB] FAIL setclr_final: got %b want 0", Busy2); end
    n_cmp++; if (ReadData2 !== 32'h45) begin n_err++; $display("[TB] FAIL setclr_data2: got %h want 45", ReadData2); end
  endtask

  task automatic test_bypass();
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h11;
    tick();
    RegWrite = 1'b1; WriteReg = 5'd9; WriteData = 32'h55; ReadReg1 = 5'd9; ReadReg2 = 5'd9;
    #1;
`ifdef REGFILE_BYPASS_EN
    n_cmp++; if (ReadData1 !== 32'h55) begin n_err++; $display("[TB] FAIL byp_rd1: got %h want 55", ReadData1); end
    n_cmp++; if (ReadData2 !== 32'h55) begin n_err++; $display("[TB] FAIL byp_rd2: got %h want 55", ReadData2); end
`else
    n_cmp++; if (ReadData1 !== 32'h11) begin n_err++; $display("[TB] FAIL byp_rd1: got %h want 11", ReadData1); end
    n_cmp++; if (ReadData2 !== 32'h11) begin n_err++; $display("[TB] FAIL byp_rd2: got %h want 11", ReadData2); end
`endif
    tick();
    idle();
    #1;
    n_cmp++; if (ReadData1 !== 32'h55) begin n_err++; $display("[TB] FAIL byp_after: got %h want 55", ReadData1); end
  endtask

  task automatic test_reset_mid();
    IssueValid = 1'b1; IssueReg = 5'd10; RegWrite = 1'b1; WriteReg = 5'd11; WriteData = 32'hBB;
    tick();
    idle(); ReadReg1 = 5'd10; ReadReg2 = 5'd11;
    #1;
    n_cmp++; if (Busy1 !== 1'b1) begin n_err++; $display("[TB] FAIL mid_busy: got %b want 1", Busy1); end
    n_cmp++; if (ReadData2 !== 32'hBB) begin n_err++; $display("[TB] FAIL mid_data: got %h want bb", ReadData2); end
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++; if (Busy1 !== 1'b0) begin n_err++; $display("[TB] FAIL async_busy: got %b want 0", Busy1); end
    n_cmp++; if (ReadData2 !== 32'h0) begin n_err++; $display("[TB] FAIL async_data: got %h want 0", ReadData2); end
    tick();
    rst_n = 1'b1;
    tick();
    n_cmp++; if (Busy1 !== 1'b0) begin n_err++; $display("[TB] FAIL mid_after_busy: got %b want 0", Busy1); end
    n_cmp++; if (ReadData2 !== 32'h0) begin n_err++; $display("[TB] FAIL mid_after_data: got %h want 0", ReadData2); end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    ReadReg1 = '0; ReadReg2 = '0; WriteReg = '0; IssueReg = '0;
    WriteData = '0;
    idle();
    test_reset();
    test_write_read();
    test_r0();
    test_scoreboard();
    test_set_clear();
    test_bypass();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 32: register width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: register count, power of two, at least 4.
REQ-003 SHALL have local parameter ADDR_W, equal to clog2(NUM_REGS): register index width.
REQ-004 SHALL have input clk, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have input rst_n, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have inputs ReadReg1 and ReadReg2, ADDR_W bits each: read port indices.
REQ-007 SHALL have outputs ReadData1 and ReadData2, DATA_W bits each: read port data.
REQ-008 SHALL have outputs Busy1 and Busy2, 1 bit each: the register indexed by ReadReg1/ReadReg2 has a pending write.
REQ-009 SHALL have inputs RegWrite (1 bit), WriteReg (ADDR_W bits) and WriteData (DATA_W bits): writeback port.
REQ-010 SHALL have inputs IssueValid (1 bit) and IssueReg (ADDR_W bits): instruction issue claiming a destination register.
REQ-011 SHALL have output Stall, 1 bit: equal to (Busy1 | Busy2) & IssueValid.

Function
REQ-012 Reads SHALL be combinational, zero latency: ReadDataN = regfile[ReadRegN].
REQ-013 Register 0 SHALL always read as 0; writes to register 0 SHALL be ignored; register 0 SHALL never be busy.
REQ-014 When RegWrite is 1 and WriteReg is nonzero, WriteData SHALL be stored at the rising edge.
REQ-015 The scoreboard SHALL hold one pending bit per register.
REQ-016 When IssueValid is 1 and IssueReg is nonzero, the pending bit for IssueReg SHALL be set at the next edge.
REQ-017 When RegWrite is 1, the pending bit for WriteReg SHALL be cleared at the next edge.
REQ-018 When issue and writeback target the same register in the same cycle, set SHALL win, so the bit stays pending.
REQ-019 BusyN SHALL be the combinational pending bit of ReadRegN, masked as described under Configuration.
REQ-020 A writeback to a non-pending register SHALL store its data and leave the pending bit at 0; no error is raised.
REQ-021 Both read ports SHALL be allowed to address the same register, with identical results.

Reset
REQ-022 Asserting rst_n low SHALL immediately clear all registers and all pending bits, independent of clk.
REQ-023 During reset, ReadData1, ReadData2, Busy1, Busy2 and Stall SHALL all be 0.
REQ-024 A write or issue presented in the cycle rst_n deasserts SHALL take effect at the first rising edge with rst_n high.
REQ-025 Reset asserted mid-operation SHALL discard all pending writes.

Configuration
REQ-026 Macro REGFILE_BYPASS_EN SHALL select write-to-read forwarding.
REQ-027 When REGFILE_BYPASS_EN is defined and RegWrite is 1 with nonzero WriteReg == ReadRegN:
- ReadDataN SHALL equal WriteData in that same cycle.
- BusyN SHALL be 0 in that same cycle, unless an issue to that register in the same cycle re-pends it at the edge.
REQ-028 When REGFILE_BYPASS_EN is undefined:
- ReadDataN SHALL return the stored value until the edge.
- BusyN SHALL remain 1 until the cycle after writeback.

Structure
REQ-029 Package regfile_pkg SHALL hold the DATA_W and NUM_REGS defaults and the reg_idx_t typedef.
REQ-030 Pending-bit logic SHALL be a sub-module rf_scoreboard with ports:
- clk, rst_n
- set_en, set_idx
- clr_en, clr_idx
- pending vector output
REQ-031 Storage, read muxing and bypass logic SHALL reside in register_file_sb.

Verification
REQ-032 The bench SHALL cover reset: hold rst_n=0 with RegWrite=1, WriteReg=5 -> after release, ReadReg1=5 returns 0 and Busy1=0.
REQ-033 The bench SHALL cover write then read: write 32'hDEADBEEF to r7, next cycle ReadReg2=7 -> ReadData2=32'hDEADBEEF.
REQ-034 The bench SHALL cover r0: write 32'h1234 to r0 and issue r0 -> ReadData1=0 and Busy1=0 on all later cycles.
REQ-035 The bench SHALL cover scoreboard: issue r3, then ReadReg1=3 -> Busy1=1 and Stall=1 with IssueValid=1; writeback r3 with 32'hA5 -> Busy1=0 after the edge.
REQ-036 The bench SHALL cover simultaneous set/clear: issue r4 and writeback r4 in the same cycle -> Busy for r4 is 1 next cycle and data equals the written value.
REQ-037 The bench SHALL cover bypass: with REGFILE_BYPASS_EN defined, write 32'h55 to r9 while ReadReg1=9 -> ReadData1=32'h55 in the same cycle; with it undefined -> ReadData1 equals the old value.
